// File: rtl/prio_arbiter_if.sv
// prio_arbiter_if
//   Bundle of the arbitration handshake between a group of requesters and
//   the prio_arbiter that serves them.
//
//   Parameters
//     N           number of requesters (2..32)
//
//   Signals
//     enable      arbitration enable, low forces the arbiter idle
//     req         level-sensitive request, one bit per channel
//     grant       one-hot grant, one bit per channel
//     grant_id    index of the granted channel, 0 when idle
//     grant_valid high while any channel owns the grant
//
//   Modports
//     master      requester side: drives enable/req, observes the grant
//     slave       arbiter side: observes enable/req, drives the grant
interface prio_arbiter_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         enable;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [W-1:0] grant_id;
    logic         grant_valid;

    modport master (
        output enable,
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  enable,
        input  req,
        output grant,
        output grant_id,
        output grant_valid
    );
endinterface

// File: rtl/prio_arbiter.sv
// prio_arbiter
//   Registered N-channel arbiter. Grants one requester at a time and keeps
//   the grant until the owner drops its request, optionally forcing a
//   re-arbitration once the owner has held the grant MAX_HOLD cycles while
//   somebody else is waiting. Winner selection is either fixed priority
//   (highest index wins) or round-robin from a rotating pointer.
//
//   Parameters
//     N           number of requesters, 2..32
//     MODE        0 = fixed priority, 1 = round-robin
//     MAX_HOLD    hold-time limit in cycles, 0 = unlimited, up to 65535
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high reset
//     bus         prio_arbiter_if slave modport
//                   enable, req          in
//                   grant, grant_id,
//                   grant_valid          out, all registered
module prio_arbiter #(
    parameter int N        = 8,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic          clk,
    input  logic          reset,
    prio_arbiter_if.slave bus
);
    localparam int           W          = $clog2(N);
    localparam logic [N-1:0] ONE_HOT_0  = N'(1);
    localparam logic [15:0]  HOLD_LIMIT = 16'(MAX_HOLD);
    localparam bit           LIMITED    = (MAX_HOLD != 0);
    localparam logic [W-1:0] LAST_CH    = W'(N - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t       state;
    logic [N-1:0] grant_q;
    logic [W-1:0] id_q;
    logic         valid_q;
    logic [W-1:0] ptr;
    logic [15:0]  hold_cnt;

    logic         holder_req;
    logic [N-1:0] others;
    logic         preempt;
    logic         keep;
    logic [N-1:0] cand;
    logic         found;
    logic [W-1:0] win;
    logic [W-1:0] next_ptr;
    int           idx;

    // Owner bookkeeping. The candidate set excludes the current owner
    // whenever a grant is active: if the owner released, its request is
    // already low, and if it is being preempted it must be masked for this
    // one arbitration. Either way the same "everyone but the owner" set is
    // correct, which is also why a release that coincides with the
    // preemption condition behaves exactly like a plain release.
    always_comb begin
        holder_req = |(bus.req & grant_q);
        others     = bus.req & ~grant_q;
        preempt    = LIMITED && valid_q && holder_req &&
                     (hold_cnt >= HOLD_LIMIT) && (|others);
        keep       = valid_q && holder_req && !preempt;
        cand       = valid_q ? others : bus.req;
    end

    // Winner selection. Fixed priority lets the highest set index win.
    // Round-robin scans downward starting at ptr and wraps from 0 back to
    // N-1 (not 2^W-1), so non-power-of-two channel counts never produce an
    // out-of-range index.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    found = 1'b1;
                    win   = W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) - k;
                if (idx < 0) begin
                    idx = idx + N;
                end
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = W'(idx);
                end
            end
        end
    end

    // After granting channel i the pointer moves to i-1 (mod N), making the
    // winner the lowest priority for the following arbitration.
    always_comb begin
        next_ptr = (win == '0) ? LAST_CH : (win - W'(1));
    end

    // Grant FSM with registered outputs. Dropping enable returns to IDLE
    // and clears the hold counter but leaves the round-robin pointer alone,
    // so fairness history survives an enable pulse. A handover from one
    // owner to the next happens on a single edge with no idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            ptr      <= LAST_CH;
            hold_cnt <= '0;
        end else if (!bus.enable) begin
            state    <= IDLE;
            grant_q  <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= OWNED;
                        grant_q  <= ONE_HOT_0 << win;
                        id_q     <= win;
                        valid_q  <= 1'b1;
                        hold_cnt <= 16'd1;
                        if (MODE != 0) begin
                            ptr <= next_ptr;
                        end
                    end
                end
                OWNED: begin
                    if (keep) begin
                        if (hold_cnt != 16'hFFFF) begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end else if (found) begin
                        grant_q  <= ONE_HOT_0 << win;
                        id_q     <= win;
                        valid_q  <= 1'b1;
                        hold_cnt <= 16'd1;
                        if (MODE != 0) begin
                            ptr <= next_ptr;
                        end
                    end else begin
                        state    <= IDLE;
                        grant_q  <= '0;
                        id_q     <= '0;
                        valid_q  <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant_q  <= '0;
                    id_q     <= '0;
                    valid_q  <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // The FSM owns every output register; the interface just exposes them.
    assign bus.grant       = grant_q;
    assign bus.grant_id    = id_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter
//   Drives three arbiter configurations side by side from one stimulus
//   stream and compares each against a behavioural model of the grant
//   rules:
//     0: N=8, fixed priority, MAX_HOLD=3
//     1: N=8, round-robin,    MAX_HOLD=4
//     2: N=5, round-robin,    unlimited hold
module tb_prio_arbiter;
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] req_fx = '0;
    logic [7:0] req_rr = '0;
    logic [4:0] req_n5 = '0;
    logic       armed  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_arbiter_if #(.N(8)) bus_fx ();
    prio_arbiter_if #(.N(8)) bus_rr ();
    prio_arbiter_if #(.N(5)) bus_n5 ();

    assign bus_fx.enable = en;
    assign bus_rr.enable = en;
    assign bus_n5.enable = en;
    assign bus_fx.req    = req_fx;
    assign bus_rr.req    = req_rr;
    assign bus_n5.req    = req_n5;

    prio_arbiter #(.N(8), .MODE(0), .MAX_HOLD(3)) dut_fx (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fx.slave)
    );

    prio_arbiter #(.N(8), .MODE(1), .MAX_HOLD(4)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr.slave)
    );

    prio_arbiter #(.N(5), .MODE(1), .MAX_HOLD(0)) dut_n5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n5.slave)
    );

    logic [31:0] dut_grant [3];
    logic [31:0] dut_id    [3];
    logic        dut_valid [3];

    assign dut_grant[0] = 32'(bus_fx.grant);
    assign dut_grant[1] = 32'(bus_rr.grant);
    assign dut_grant[2] = 32'(bus_n5.grant);
    assign dut_id[0]    = 32'(bus_fx.grant_id);
    assign dut_id[1]    = 32'(bus_rr.grant_id);
    assign dut_id[2]    = 32'(bus_n5.grant_id);
    assign dut_valid[0] = bus_fx.grant_valid;
    assign dut_valid[1] = bus_rr.grant_valid;
    assign dut_valid[2] = bus_n5.grant_valid;

    // Behavioural model state, one slot per configuration.
    int m_valid [3];
    int m_id    [3];
    int m_ptr   [3];
    int m_hold  [3];

    function automatic int cfg_n(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int cfg_mode(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int cfg_max(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 4 : 0);
    endfunction

    function automatic logic [31:0] model_grant(input int i);
        return (m_valid[i] != 0) ? (32'd1 << m_id[i]) : 32'd0;
    endfunction

    // Priority order as a list: fixed mode walks N-1..0, round-robin walks
    // ptr, ptr-1, ... wrapping modulo N. First requester on the list wins.
    function automatic int pick(input int i, input logic [31:0] cand);
        int n;
        int w;
        int b;
        n = cfg_n(i);
        w = -1;
        for (int k = 0; k < n; k++) begin
            if (cfg_mode(i) == 0) b = n - 1 - k;
            else                  b = (m_ptr[i] - k + n) % n;
            if (w < 0 && cand[b]) w = b;
        end
        return w;
    endfunction

    function automatic void model_take(input int i, input int w);
        m_valid[i] = 1;
        m_id[i]    = w;
        m_hold[i]  = 1;
        if (cfg_mode(i) == 1) m_ptr[i] = (w + cfg_n(i) - 1) % cfg_n(i);
    endfunction

    function automatic void model_idle(input int i);
        m_valid[i] = 0;
        m_id[i]    = 0;
        m_hold[i]  = 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            model_idle(i);
            m_ptr[i] = cfg_n(i) - 1;
        end
    endfunction

    // One clock edge of the grant rules.
    function automatic void model_step(input int i, input logic e, input logic [31:0] r);
        logic [31:0] others;
        int          w;
        if (!e) begin
            model_idle(i);
            return;
        end
        if (m_valid[i] == 0) begin
            w = pick(i, r);
            if (w >= 0) model_take(i, w);
            return;
        end
        others = r & ~(32'd1 << m_id[i]);
        if (r[m_id[i]] && !(cfg_max(i) > 0 && m_hold[i] >= cfg_max(i) && others != 0)) begin
            if (m_hold[i] < 65535) m_hold[i] = m_hold[i] + 1;
        end else begin
            w = pick(i, others);
            if (w >= 0) model_take(i, w);
            else        model_idle(i);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, advance the model at
    // the rising edge, and return at the next falling edge.
    task automatic applyStimulus(input logic e, input logic [7:0] rf,
                                 input logic [7:0] rr, input logic [4:0] rn);
        en     = e;
        req_fx = rf;
        req_rr = rr;
        req_n5 = rn;
        @(posedge clk);
        model_step(0, e, 32'(rf));
        model_step(1, e, 32'(rr));
        model_step(2, e, 32'(rn));
        @(negedge clk);
    endtask

    // Reset is raised between edges so its effect must be asynchronous.
    task automatic doReset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_grant%0d", i), dut_grant[i], 32'd0);
            checkOutput($sformatf("reset_valid%0d", i), 32'(dut_valid[i]), 32'd0);
            checkOutput($sformatf("reset_id%0d", i), dut_id[i], 32'd0);
        end
        armed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en     = 1'b0;
        req_fx = '0;
        req_rr = '0;
        req_n5 = '0;
        reset  = 1'b0;
    endtask

    // Per-cycle comparison of every configuration against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 3; i++) begin
                    checkOutput($sformatf("grant%0d", i), dut_grant[i], model_grant(i));
                    checkOutput($sformatf("grant_id%0d", i), dut_id[i], 32'(m_id[i]));
                    checkOutput($sformatf("grant_valid%0d", i), 32'(dut_valid[i]), 32'(m_valid[i]));
                    checkOutput($sformatf("onehot%0d", i), 32'($onehot0(dut_grant[i])), 32'd1);
                    checkOutput($sformatf("id_range%0d", i), 32'(dut_id[i] < 32'(cfg_n(i))), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [7:0] rf;
        logic [7:0] rr;
        logic [4:0] rn;
        logic       e;

        @(negedge clk);
        doReset();

        // Fixed priority: highest index wins, handover without a bubble.
        applyStimulus(1'b1, 8'b0010_0110, 8'h00, 5'h00);
        checkOutput("fx_first_id", dut_id[0], 32'd5);
        checkOutput("fx_first_model", 32'(m_id[0]), 32'd5);
        checkOutput("fx_first_valid", 32'(dut_valid[0]), 32'd1);
        applyStimulus(1'b1, 8'b0000_0110, 8'h00, 5'h00);
        checkOutput("fx_handover_id", dut_id[0], 32'd2);
        checkOutput("fx_handover_valid", 32'(dut_valid[0]), 32'd1);
        applyStimulus(1'b1, 8'h00, 8'h00, 5'h00);
        checkOutput("fx_release_valid", 32'(dut_valid[0]), 32'd0);
        checkOutput("fx_release_grant", dut_grant[0], 32'd0);

        // Reset while channels own grants, then quiet afterwards.
        applyStimulus(1'b1, 8'h40, 8'h40, 5'h01);
        checkOutput("fx_pre_reset_grant", dut_grant[0], 32'h40);
        doReset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 8'h00, 8'h00, 5'h00);
            checkOutput("post_reset_valid", 32'(dut_valid[0]), 32'd0);
        end

        // Round-robin rotation with all requesting and one-cycle ownership.
        for (int k = 0; k < 9; k++) begin
            rr = 8'hFF & ~8'(model_grant(1));
            applyStimulus(1'b1, 8'h00, rr, 5'h00);
            checkOutput("rr_order_id", dut_id[1], 32'((7 - (k % 8))));
            checkOutput("rr_order_model", 32'(m_id[1]), 32'((7 - (k % 8))));
        end

        // Preemption: channels 3 and 1 alternate every four cycles.
        doReset();
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b1, 8'h00, 8'b0000_1010, 5'h00);
            checkOutput("rr_preempt_id", dut_id[1], (((k / 4) % 2) == 0) ? 32'd3 : 32'd1);
            checkOutput("rr_preempt_model", 32'(m_id[1]), (((k / 4) % 2) == 0) ? 32'd3 : 32'd1);
        end
        doReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 8'h00, 8'b0000_1000, 5'h00);
            checkOutput("rr_alone_id", dut_id[1], 32'd3);
        end

        // Enable drop forces idle; re-enable regrants the waiting channel.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h40, 8'h48, 5'h00);
        applyStimulus(1'b0, 8'h40, 8'h48, 5'h00);
        checkOutput("en_off_valid", 32'(dut_valid[0]), 32'd0);
        checkOutput("en_off_id", dut_id[0], 32'd0);
        applyStimulus(1'b1, 8'h40, 8'h48, 5'h00);
        checkOutput("en_on_id", dut_id[0], 32'd6);
        checkOutput("en_on_valid", 32'(dut_valid[0]), 32'd1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'h40, 8'h48, 5'h00);

        // Five channels: 4 and 0 alternate with a wrap from 0 to 4.
        doReset();
        for (int k = 0; k < 8; k++) begin
            rn = 5'b10001 & ~5'(model_grant(2));
            applyStimulus(1'b1, 8'h00, 8'h00, rn);
            checkOutput("n5_alt_id", dut_id[2], ((k % 2) == 0) ? 32'd4 : 32'd0);
            checkOutput("n5_alt_model", 32'(m_id[2]), ((k % 2) == 0) ? 32'd4 : 32'd0);
        end

        // Randomised traffic; requests are sticky so holds and preemption occur.
        rf = '0;
        rr = '0;
        rn = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) doReset();
            e = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) rf = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rn = 5'($urandom);
            if ($urandom_range(0, 5) == 0 && m_valid[0] != 0) rf = rf & ~8'(model_grant(0));
            if ($urandom_range(0, 5) == 0 && m_valid[1] != 0) rr = rr & ~8'(model_grant(1));
            if ($urandom_range(0, 5) == 0 && m_valid[2] != 0) rn = rn & ~5'(model_grant(2));
            applyStimulus(e, rf, rr, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
